wb_arbiter2: RTL

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arbiter2_if.sv | 15 +
 rtl/wb_arbiter2.sv | 61 ++++++
 2 files changed

// File: rtl/wb_arbiter2_if.sv
// wb_if: Wishbone B4 pipelined bundle with master and slave views.
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;
  logic        stall;
  modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack, err, stall);
  modport slave (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack, err, stall);
endinterface

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master Wishbone B4 pipelined arbiter with alternating priority and outstanding-transfer limit.
module wb_arbiter2 #(
  parameter int MAX_OUTSTANDING = 4
) (
  input logic  clk,
  input logic  rst,
  wb_if.slave  m0,
  wb_if.slave  m1,
  wb_if.master s
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t     state_q, state_d;
  logic       prio_q, prio_d;
  logic [2:0] cnt_q, cnt_d;
  logic       own, act, req_cyc, full, acc, rsp;
  always_comb begin
    own = state_q == OWN1;
    act = state_q != IDLE && !rst;
    req_cyc = act && (own ? m1.cyc : m0.cyc);
    full = cnt_q == 3'(MAX_OUTSTANDING);
    s.cyc = req_cyc;
    s.stb = req_cyc && !full && (own ? m1.stb : m0.stb);
    s.we = own ? m1.we : m0.we;
    s.sel = own ? m1.sel : m0.sel;
    s.adr = own ? m1.adr : m0.adr;
    s.dat_w = own ? m1.dat_w : m0.dat_w;
    acc = s.stb && !s.stall;
    // responses with nothing outstanding (e.g. after abort or reset) are dropped
    rsp = req_cyc && cnt_q != 3'd0 && (s.ack || s.err);
    m0.ack = rsp && !own && s.ack;
    m0.err = rsp && !own && s.err;
    m1.ack = rsp && own && s.ack;
    m1.err = rsp && own && s.err;
    m0.stall = !(act && !own) || s.stall || full;
    m1.stall = !(act && own) || s.stall || full;
    m0.dat_r = s.dat_r;
    m1.dat_r = s.dat_r;
    state_d = state_q;
    prio_d = prio_q;
    cnt_d = cnt_q + {2'b0, acc} - {2'b0, rsp};
    if (state_q == IDLE) begin
      cnt_d = 3'd0;
      state_d = (m0.cyc && (!m1.cyc || !prio_q)) ? OWN0 : m1.cyc ? OWN1 : IDLE;
    end else if (!req_cyc) begin
      state_d = IDLE;
      prio_d = !own;
      cnt_d = 3'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q <= 1'b0;
      cnt_q <= 3'd0;
    end else begin
      state_q <= state_d;
      prio_q <= prio_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
